// File: rtl/shuffle_pkg.sv
// Shared types and defaults for the shuffle/solve sequencer.
package shuffle_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        GAP   = 3'd2,
        ARMED = 3'd3,
        SOLVE = 3'd4
    } state_t;

    localparam int unsigned DEF_MOVES = 20;
    localparam int unsigned DEF_GAP   = 4;

    // A zero request selects the default burst length.
    function automatic int unsigned resolve_target(input int unsigned num,
                                                   input int unsigned dflt = DEF_MOVES);
        return (num == 0) ? dflt : num;
    endfunction

endpackage

// File: rtl/shuffle_solve_ctrl_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after d goes high.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= d;
            r_rise <= d & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule

// File: rtl/shuffle_solve_ctrl.sv
// Turns a scramble press into a burst of handshaked random-move requests,
// then arms the solve phase, gates the buzzer and reports completion.
module shuffle_solve_ctrl
    import shuffle_pkg::*;
#(
    parameter int unsigned MOVE_CNT_W    = 6,
    parameter int unsigned DEFAULT_MOVES = DEF_MOVES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP,
    parameter int unsigned GAP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mix_state,
    input  logic                  scramble_btn,
    input  logic [MOVE_CNT_W-1:0] num_moves,
    input  logic                  rand_ack,
    input  logic                  solved,
    output logic                  random_please,
    output logic                  no_buzz,
    output logic                  scramble_busy,
    output logic [MOVE_CNT_W-1:0] move_idx,
    output logic                  solve_done
);

    // A zero gap still leaves one idle cycle between requests.
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [MOVE_CNT_W-1:0] r_target;
    logic [MOVE_CNT_W-1:0] r_move_idx;
    logic [MOVE_CNT_W-1:0] w_idx_inc;
    logic [GAP_CNT_W-1:0]  r_gap;
    logic                  w_btn_rise;
    logic                  w_solved_rise;
    logic                  w_last_move;
    logic                  w_solve_hit;
    logic                  r_random_please;
    logic                  r_no_buzz;
    logic                  r_busy;
    logic                  r_solve_done;

    rise_detect u_btn_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (scramble_btn),
        .rise  (w_btn_rise)
    );

    rise_detect u_solved_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (solved),
        .rise  (w_solved_rise)
    );

    assign w_idx_inc   = r_move_idx + MOVE_CNT_W'(1);
    assign w_last_move = (w_idx_inc == r_target);

    always_comb begin
        w_next      = r_state;
        w_solve_hit = 1'b0;
        case (r_state)
            IDLE:  if (w_btn_rise && !mix_state) w_next = REQ;
            REQ:   if (rand_ack) w_next = w_last_move ? ARMED : GAP;
            GAP:   if (r_gap == GAP_LAST) w_next = REQ;
            ARMED: if (mix_state) w_next = SOLVE;
            SOLVE: begin
                // A solve in the same cycle as leaving solve mode still counts.
                if (w_solved_rise) begin
                    w_solve_hit = 1'b1;
                    w_next      = IDLE;
                end else if (!mix_state) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_target        <= '0;
            r_move_idx      <= '0;
            r_gap           <= '0;
            r_random_please <= 1'b0;
            r_no_buzz       <= 1'b1;
            r_busy          <= 1'b0;
            r_solve_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == REQ) begin
                r_target   <= MOVE_CNT_W'(resolve_target(32'(num_moves), DEFAULT_MOVES));
                r_move_idx <= '0;
            end else if (r_state == REQ && rand_ack) begin
                r_move_idx <= w_idx_inc;
            end
            r_gap           <= (r_state == GAP) ? r_gap + GAP_CNT_W'(1) : '0;
            // Outputs are decoded from the next state so they are registered.
            r_random_please <= (w_next == REQ);
            r_busy          <= (w_next == REQ) || (w_next == GAP);
            r_no_buzz       <= (w_next != SOLVE);
            r_solve_done    <= w_solve_hit;
        end
    end

    assign random_please = r_random_please;
    assign no_buzz       = r_no_buzz;
    assign scramble_busy = r_busy;
    assign move_idx      = r_move_idx;
    assign solve_done    = r_solve_done;

endmodule

// File: tb/tb_shuffle_solve_ctrl.sv
// Randomised bench for shuffle_solve_ctrl against a transaction-level model
// of burst length, gap length, handshake and solve behaviour.
module tb_shuffle_solve_ctrl;

    localparam int MW     = 6;
    localparam int DEFM   = 20;
    localparam int GAPC   = 4;
    localparam int GAPEFF = (GAPC == 0) ? 1 : GAPC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mix_state = 1'b0;
    logic          scramble_btn = 1'b0;
    logic [MW-1:0] num_moves = '0;
    logic          rand_ack = 1'b0;
    logic          solved = 1'b0;
    logic          random_please;
    logic          no_buzz;
    logic          scramble_busy;
    logic [MW-1:0] move_idx;
    logic          solve_done;

    int checkCount = 0;
    int errorCount = 0;

    shuffle_solve_ctrl #(
        .MOVE_CNT_W    (MW),
        .DEFAULT_MOVES (DEFM),
        .GAP_CYCLES    (GAPC),
        .GAP_CNT_W     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mix_state     (mix_state),
        .scramble_btn  (scramble_btn),
        .num_moves     (num_moves),
        .rand_ack      (rand_ack),
        .solved        (solved),
        .random_please (random_please),
        .no_buzz       (no_buzz),
        .scramble_busy (scramble_busy),
        .move_idx      (move_idx),
        .solve_done    (solve_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ackDelay < 0 picks a random delay per move; solveMode 0 = solve,
    // 1 = solved already high before solve mode, 2 = abort by leaving solve mode.
    task automatic applyStimulus(input int nm, input int ackDelay, input bit noisy,
                                 input int resetAt, input int solveMode);
        int target;
        int d;
        int lowCnt;
        int waitCnt;
        target       = (nm == 0) ? DEFM : nm;
        num_moves    = MW'(nm);
        mix_state    = 1'b0;
        scramble_btn = 1'b1;
        tick();
        checkOutput("latencyEarly", int'(random_please), 0);
        if (!noisy) scramble_btn = 1'b0;
        tick();
        checkOutput("latencyReq", int'(random_please), 1);
        checkOutput("busyStart", int'(scramble_busy), 1);
        num_moves = MW'($urandom_range(0, 63));
        for (int k = 0; k < target; k++) begin
            checkOutput("idxReq", int'(move_idx), k);
            if (k == resetAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rstReq", int'(random_please), 0);
                checkOutput("rstBusy", int'(scramble_busy), 0);
                checkOutput("rstBuzz", int'(no_buzz), 1);
                checkOutput("rstIdx", int'(move_idx), 0);
                checkOutput("rstDone", int'(solve_done), 0);
                tick();
                tick();
                checkOutput("rstHold", int'(random_please), 0);
                rst_n        = 1'b1;
                scramble_btn = 1'b0;
                mix_state    = 1'b0;
                rand_ack     = 1'b0;
                tick();
                checkOutput("rstAfter", int'(random_please), 0);
                return;
            end
            d = (ackDelay < 0) ? int'($urandom_range(0, 7)) : ackDelay;
            for (int i = 0; i < d; i++) begin
                checkOutput("reqHeld", int'(random_please), 1);
                tick();
            end
            checkOutput("reqAtAck", int'(random_please), 1);
            rand_ack = 1'b1;
            tick();
            rand_ack = 1'b0;
            checkOutput("idxAck", int'(move_idx), k + 1);
            checkOutput("reqDrop", int'(random_please), 0);
            if (k + 1 < target) begin
                lowCnt = 0;
                while (random_please == 1'b0 && lowCnt < 50) begin
                    lowCnt++;
                    checkOutput("gapIdx", int'(move_idx), k + 1);
                    checkOutput("gapBusy", int'(scramble_busy), 1);
                    if (noisy) begin
                        scramble_btn = 1'($urandom_range(0, 1));
                        mix_state    = 1'($urandom_range(0, 1));
                    end
                    rand_ack = 1'($urandom_range(0, 1));
                    tick();
                end
                rand_ack = 1'b0;
                checkOutput("gapLen", lowCnt, GAPEFF);
            end else begin
                scramble_btn = 1'b0;
                mix_state    = 1'b0;
                checkOutput("busyEnd", int'(scramble_busy), 0);
                checkOutput("armedBuzz", int'(no_buzz), 1);
                checkOutput("finalIdx", int'(move_idx), target);
            end
        end
        tick();
        checkOutput("armedQuiet", int'(random_please), 0);
        checkOutput("armedIdx", int'(move_idx), target);
        if (solveMode == 1) begin
            solved = 1'b1;
            tick();
            tick();
        end
        mix_state = 1'b1;
        tick();
        checkOutput("solveBuzz", int'(no_buzz), 0);
        checkOutput("solveNoDone", int'(solve_done), 0);
        if (solveMode == 2) begin
            mix_state = 1'b0;
            tick();
            checkOutput("abortBuzz", int'(no_buzz), 1);
            for (int i = 0; i < 3; i++) begin
                checkOutput("abortNoDone", int'(solve_done), 0);
                tick();
            end
        end else begin
            if (solveMode == 1) begin
                for (int i = 0; i < 3; i++) begin
                    checkOutput("preHighNoDone", int'(solve_done), 0);
                    tick();
                end
                solved = 1'b0;
                tick();
            end
            solved  = 1'b1;
            waitCnt = 0;
            while (solve_done == 1'b0 && waitCnt < 6) begin
                tick();
                waitCnt++;
            end
            checkOutput("solvePulse", int'(solve_done), 1);
            checkOutput("solveLatency", waitCnt, 2);
            checkOutput("doneBuzz", int'(no_buzz), 1);
            tick();
            checkOutput("pulseWidth", int'(solve_done), 0);
            solved    = 1'b0;
            mix_state = 1'b0;
            tick();
        end
        checkOutput("idleQuiet", int'(random_please), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("resetReq", int'(random_please), 0);
        checkOutput("resetBuzz", int'(no_buzz), 1);
        checkOutput("resetBusy", int'(scramble_busy), 0);
        checkOutput("resetIdx", int'(move_idx), 0);
        checkOutput("resetDone", int'(solve_done), 0);
        rst_n = 1'b1;
        tick();

        applyStimulus(3, 1, 1'b0, -1, 0);
        applyStimulus(0, 1, 1'b0, -1, 0);
        applyStimulus(4, 7, 1'b0, -1, 1);
        applyStimulus(5, -1, 1'b1, -1, 0);
        applyStimulus(6, -1, 1'b0, 2, 0);
        applyStimulus(3, 0, 1'b0, -1, 2);

        mix_state    = 1'b1;
        scramble_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("solveModeIgnore", int'(random_please), 0);
            checkOutput("solveModeBusy", int'(scramble_busy), 0);
        end
        scramble_btn = 1'b0;
        mix_state    = 1'b0;
        tick();

        for (int n = 0; n < 6; n++) begin
            applyStimulus(int'($urandom_range(0, 63)), -1, 1'($urandom_range(0, 1)),
                          -1, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/shuffle_solve_ctrl.md
Name: shuffle_solve_ctrl

Overview:
Sequential successor to the combinational shuffle/solve state decode. It turns one scramble-button press into a parametrised burst of random-move requests. Each request uses a request/acknowledge handshake with the move generator and is followed by an inter-move gap. The block then arms the solve phase and gates the buzzer, and reports when the puzzle is solved. It sits between the button/mode inputs and the random-move generator and buzzer driver.

Parameters:
MOVE_CNT_W, 6, width of move count/index; max burst 2^MOVE_CNT_W-1
DEFAULT_MOVES, 20, burst length used when num_moves==0; legal range 1..2^MOVE_CNT_W-1
GAP_CYCLES, 4, idle cycles between consecutive move requests; 0 is treated as 1
GAP_CNT_W, 8, width of gap counter; GAP_CYCLES < 2^GAP_CNT_W

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mix_state  in  1  0 = mix mode (buzzer muted, scrambling allowed), 1 = solve mode
scramble_btn  in  1  scramble request level, already synchronised/debounced
num_moves  in  MOVE_CNT_W  requested burst length, sampled at start; 0 selects DEFAULT_MOVES
rand_ack  in  1  move generator accepted current request
solved  in  1  puzzle-solved level from checker
random_please  out  1  move request, held high until acknowledged
no_buzz  out  1  1 = buzzer muted
scramble_busy  out  1  high while a burst is in progress
move_idx  out  MOVE_CNT_W  number of moves acknowledged in current burst
solve_done  out  1  one-cycle pulse on solve completion

Behaviour:
- Reset: one clock domain; rst_n is asynchronous and active-low. Assertion immediately forces IDLE, random_please=0, no_buzz=1, scramble_busy=0, move_idx=0, solve_done=0, edge-detector history=0. It is legal at any point, including mid-burst. An outstanding request is simply dropped.
- All outputs are registered.
- Button and solved inputs are edge-qualified: a rising edge means low in the previous cycle and high in this one.
- States: IDLE, REQ, GAP, ARMED, SOLVE.
- IDLE: no_buzz=1.
  - A scramble_btn rise while mix_state==0 latches target = (num_moves==0 ? DEFAULT_MOVES : num_moves) and clears move_idx. Next state is REQ.
  - A button rise while mix_state==1 is ignored.
- REQ: random_please=1, scramble_busy=1, no_buzz=1.
  - On a cycle with rand_ack=1, move_idx increments.
  - If the new move_idx==target, next state is ARMED; otherwise next state is GAP.
  - random_please drops the cycle after ack.
  - rand_ack while not in REQ is ignored.
- GAP: random_please=0, busy=1. Stays for max(GAP_CYCLES,1) cycles, then returns to REQ.
- Latency: a button rise sampled at edge N gives random_please=1 after edge N+1. Between requests, random_please is low for at least max(GAP_CYCLES,1) cycles.
- During REQ/GAP: mix_state changes and further button presses are ignored. The burst always completes.
- ARMED: busy=0, no_buzz=1, move_idx holds final count. When mix_state==1, next state is SOLVE.
- SOLVE: no_buzz=0.
  - A solved rise gives solve_done=1 for exactly one cycle, then IDLE.
  - mix_state returning to 0 gives abort to IDLE with no solve_done.
  - If both happen in the same cycle, solved wins.
  - solved already high on entry does not count; a new rise is required.
- move_idx never wraps, because target ≤ 2^MOVE_CNT_W-1.

Decomposition:
- Package shuffle_pkg: state enum (IDLE, REQ, GAP, ARMED, SOLVE), default constants for DEFAULT_MOVES/GAP_CYCLES, and a function resolve_target(num_moves).
- Sub-module rise_detect (clk, rst_n, d, rise), instantiated for scramble_btn and solved.
- Everything else is inline.

Test Plan:
- Reset, then mix_state=0, num_moves=3, GAP_CYCLES=4, button pulse, rand_ack 1 cycle after each request → exactly 3 random_please pulses. Each gap is 4 low cycles. move_idx steps 0→1→2→3 and busy falls after the 3rd ack.
- num_moves=0, same stimulus → 20 requests, move_idx ends at 20, state ARMED, no_buzz=1.
- After burst, mix_state=1 → no_buzz=0. A solved rise → solve_done high for 1 cycle, no_buzz=1 next cycle, state IDLE. With solved held high on SOLVE entry → no pulse until a new rise.
- Button held high through a burst, second press mid-burst, mix_state toggled mid-burst → single burst of num_moves requests, no restart.
- rand_ack delayed 7 cycles → random_please stays high all 7 cycles and move_idx increments once. rand_ack during GAP → ignored.
- rst_n low during REQ with move_idx=2 → outputs immediately go to reset values, no further requests. After release, a new press starts from move_idx=0.
